// File: rtl/calc_ctrl_pkg.sv
// calc_ctrl shared types.
// State and operation-class encodings for the calculate phase.
package calc_ctrl_pkg;

  typedef enum logic [2:0] {
    C_IDLE,
    C_ISSUE,
    C_WAIT,
    C_DONE,
    C_DRAIN,
    C_ERR
  } CalcState;

  typedef enum logic [2:0] {
    OP_ALU = 3'd0,
    OP_MUL = 3'd1,
    OP_DIV = 3'd2
  } CalcOp;

  function automatic logic op_legal(input CalcOp o);
    return (o == OP_ALU) || (o == OP_MUL) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/calc_ctrl_cycle_counter.sv
// Saturating WAIT-cycle counter.
// Clear wins over enable; holds at all-ones.
module cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // count up while enabled, stop at the top value
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/calc_ctrl.sv
// Multicycle execute controller for the calculate phase.
// Launches mul/div, tracks completion, reports done or fault.
module calc_ctrl
  import calc_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       calc_en,
  input  CalcOp                      op,
  input  logic                       b_zero,
  input  logic                       unit_done,
  output logic                       unit_start,
  output logic                       unit_sel,
  output logic                       unit_abort,
  output logic                       busy,
  output logic                       nxt_line,
  output logic                       err,
  output logic [$clog2(TIMEOUT)-1:0] cyc_cnt
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] MUL_LAST = W'(MUL_CYCLES - 1);
  localparam logic [W-1:0] TO_LAST  = W'(TIMEOUT - 1);

  CalcState state, nxt_state;
  CalcOp    op_q;
  logic     abort_d;

  cycle_counter #(.W(W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == C_ISSUE),
    .en  (state == C_WAIT),
    .cnt (cyc_cnt)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= C_IDLE;
    else
      state <= nxt_state;
  end

  // latch the operation class at launch; later op changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_q <= OP_ALU;
    else if ((state == C_IDLE) && calc_en)
      op_q <= op;
  end

  // abort is registered so it has no path from calc_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      unit_abort <= 1'b0;
    else
      unit_abort <= abort_d;
  end

  // next state, abort request and state-decoded outputs
  always_comb begin
    nxt_state  = state;
    abort_d    = 1'b0;
    unit_start = 1'b0;
    busy       = 1'b0;
    nxt_line   = 1'b0;
    err        = 1'b0;
    unique case (state)
      C_IDLE: begin
        if (calc_en) begin
          unique case (1'b1)
            !op_legal(op):            nxt_state = C_ERR;
            op == OP_ALU:             nxt_state = C_DONE;
            op == OP_DIV && b_zero:   nxt_state = C_ERR;
            default:                  nxt_state = C_ISSUE;
          endcase
        end
      end
      C_ISSUE: begin
        unit_start = 1'b1;
        busy       = 1'b1;
        if (!calc_en) begin
          nxt_state = C_IDLE;
          abort_d   = 1'b1;
        end else begin
          nxt_state = C_WAIT;
        end
      end
      C_WAIT: begin
        busy = 1'b1;
        if (!calc_en) begin
          nxt_state = C_IDLE;
          abort_d   = 1'b1;
        end else if (op_q == OP_MUL) begin
          if (cyc_cnt == MUL_LAST)
            nxt_state = C_DONE;
        end else if (unit_done) begin
          nxt_state = C_DONE;
        end else if (cyc_cnt == TO_LAST) begin
          nxt_state = C_ERR;
        end
      end
      C_DONE: begin
        nxt_line  = 1'b1;
        nxt_state = calc_en ? C_DRAIN : C_IDLE;
      end
      C_DRAIN: begin
        if (!calc_en)
          nxt_state = C_IDLE;
      end
      C_ERR: begin
        err = 1'b1;
      end
      default: nxt_state = C_IDLE;
    endcase
  end

  assign unit_sel = busy && (op_q == OP_DIV);

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl.
// Directed cases then random ops against a latency model.
module tb_calc_ctrl;
  import calc_ctrl_pkg::*;

  localparam int M = 4;
  localparam int T = 16;
  localparam int W = $clog2(T);

  logic         clk = 1'b0;
  logic         rst;
  logic         calc_en;
  CalcOp        op;
  logic         b_zero;
  logic         unit_done;
  logic         unit_start;
  logic         unit_sel;
  logic         unit_abort;
  logic         busy;
  logic         nxt_line;
  logic         err;
  logic [W-1:0] cyc_cnt;

  int errors = 0;
  int checks = 0;

  calc_ctrl #(.MUL_CYCLES(M), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .calc_en    (calc_en),
    .op         (op),
    .b_zero     (b_zero),
    .unit_done  (unit_done),
    .unit_start (unit_start),
    .unit_sel   (unit_sel),
    .unit_abort (unit_abort),
    .busy       (busy),
    .nxt_line   (nxt_line),
    .err        (err),
    .cyc_cnt    (cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic sl,
                         input logic ab, input logic bs, input logic nl,
                         input logic er);
    chk({tag, ".unit_start"}, 32'(unit_start), 32'(s));
    chk({tag, ".unit_sel"},   32'(unit_sel),   32'(sl));
    chk({tag, ".unit_abort"}, 32'(unit_abort), 32'(ab));
    chk({tag, ".busy"},       32'(busy),       32'(bs));
    chk({tag, ".nxt_line"},   32'(nxt_line),   32'(nl));
    chk({tag, ".err"},        32'(err),        32'(er));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    calc_en   = 1'b0;
    unit_done = 1'b0;
    rst       = 1'b1;
    #1;
    chk_all(tag, 0, 0, 0, 0, 0, 0);
    chk({tag, ".cyc_cnt"}, 32'(cyc_cnt), 0);
    tick;
    rst = 1'b0;
    tick;
  endtask

  // One launch; expectations come from the latency rules only.
  // dw: WAIT index of unit_done for DIV (>=T means never).
  // a : cycle after launch in which calc_en drops (0 = no abort).
  task automatic run_txn(input string tag, input int o, input bit bz,
                         input int dw, input int a);
    int  done_k = 0;
    int  err_k = 0;
    int  last_busy = 0;
    int  end_k;
    bit  unit_op = 0;
    bit  aborted;
    bit  div_ok;
    bit  e_busy;
    div_ok = (o == 2) && !bz;
    if (o == 0) begin
      done_k = 1;
    end else if (o == 1) begin
      unit_op = 1;
      done_k  = 2 + M;
    end else if (div_ok) begin
      unit_op = 1;
      if (dw >= 0 && dw < T) done_k = 3 + dw;
      else                   err_k  = 2 + T;
    end else begin
      err_k = 1;
    end
    if (unit_op) last_busy = (done_k != 0 ? done_k : err_k) - 1;
    aborted = unit_op && a >= 1 && a <= last_busy;
    end_k = aborted ? a + 3 : (done_k != 0 ? done_k + 3 : err_k + 2);

    op        = CalcOp'(3'(o));
    b_zero    = bz;
    calc_en   = 1'b1;
    unit_done = 1'b0;
    for (int k = 1; k <= end_k; k++) begin
      tick;
      e_busy = unit_op && k <= last_busy && (!aborted || k <= a);
      chk_all($sformatf("%s.k%0d", tag, k),
              unit_op && k == 1,
              e_busy && o == 2,
              aborted && k == a + 1,
              e_busy,
              !aborted && done_k != 0 && k == done_k,
              !aborted && err_k != 0 && k >= err_k);
      if (e_busy && k >= 2)
        chk($sformatf("%s.k%0d.cyc_cnt", tag, k), 32'(cyc_cnt), 32'(k - 2));
      op     = CalcOp'(3'($urandom_range(0, 7)));
      b_zero = 1'($urandom_range(0, 1));
      if (aborted)          calc_en = (k < a);
      else if (err_k != 0)  calc_en = 1'b1;
      else                  calc_en = (k < done_k + 2);
      if (div_ok)
        unit_done = (done_k != 0 && k == 2 + dw) ||
                    ((k == 1 || k > last_busy) && 1'($urandom_range(0, 1)));
      else
        unit_done = 1'($urandom_range(0, 1));
    end
    calc_en   = 1'b0;
    unit_done = 1'b0;
    if (!aborted && err_k != 0) do_reset({tag, ".rst"});
  endtask

  initial begin
    rst     = 1'b1;
    calc_en = 1'b0;
    op      = OP_ALU;
    b_zero  = 1'b0;
    unit_done = 1'b0;
    do_reset("reset");

    run_txn("alu_drain", 0, 0, -1, 0);
    run_txn("mul", 1, 0, -1, 0);
    run_txn("div_done3", 2, 0, 3, 0);
    run_txn("div_abort_vs_done", 2, 0, 3, 5);
    run_txn("div_timeout", 2, 0, T, 0);
    run_txn("div_done_at_last", 2, 0, T - 1, 0);
    run_txn("div_bzero", 2, 1, -1, 0);
    run_txn("illegal5", 5, 0, -1, 0);
    run_txn("mul_abort_last", 1, 0, -1, 1 + M);

    op      = OP_MUL;
    b_zero  = 1'b0;
    calc_en = 1'b1;
    tick;
    tick;
    tick;
    chk("midwait.busy", 32'(busy), 1);
    chk("midwait.cyc_cnt", 32'(cyc_cnt), 1);
    do_reset("midwait_rst");
    run_txn("after_rst_alu", 0, 0, -1, 0);

    for (int i = 0; i < 60; i++) begin
      int o;
      int dw;
      int a;
      bit bz;
      o  = $urandom_range(0, 5);
      bz = ($urandom_range(0, 3) == 0);
      dw = $urandom_range(0, T + 1);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + M) : 0;
      run_txn($sformatf("rnd%0d", i), o, bz, dw, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Multicycle execute controller for the CPU's calculate phase. Active while the top-level sequencer sits in SCALC. Decodes the latched operation class and either completes immediately (single-cycle ALU) or launches the shared multiply/divide unit. It then counts or waits for completion and returns a one-cycle `nxt_line` pulse (advance to SWRITE) or a sticky `err` (force SERR).

## Interface
Parameters:
- `MUL_CYCLES`, default 4: fixed multiply latency in cycles (1..`TIMEOUT`).
- `TIMEOUT`, default 16: maximum divide wait in cycles before fault (power of 2, ≥2).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `calc_en` input 1: high while sequencer state == SCALC.
- `op` input `CalcOp` (3): operation class. Sampled only on launch.
- `b_zero` input 1: operand B equals zero. Sampled only on launch.
- `unit_done` input 1: divide unit completion strobe.
- `unit_start` output 1: one-cycle launch pulse to the mul/div unit.
- `unit_sel` output 1: 0 = multiply, 1 = divide. Valid when `unit_start` or `busy` is high.
- `unit_abort` output 1: one-cycle pulse when `calc_en` drops mid-operation.
- `busy` output 1: high in ISSUE/WAIT.
- `nxt_line` output 1: one-cycle completion pulse to the sequencer.
- `err` output 1: sticky fault to the sequencer.
- `cyc_cnt` output `$clog2(TIMEOUT)`: WAIT-cycle counter, for debug.

## Operation
- The block is reset-only to exit fault: `rst` async-clears everything.
- Reset values: state C_IDLE, and all outputs 0 (`unit_start`, `unit_sel`, `unit_abort`, `busy`, `nxt_line`, `err`, `cyc_cnt`).
- `CalcOp` encodings: OP_ALU=0, OP_MUL=1, OP_DIV=2. Codes 3..7 are illegal.

State machine (`CalcState`): C_IDLE, C_ISSUE, C_WAIT, C_DONE, C_DRAIN, C_ERR.
- **C_IDLE**
  - `calc_en`=0: stay.
  - `calc_en`=1: latch `op`.
  - OP_ALU → C_DONE.
  - OP_MUL → C_ISSUE.
  - OP_DIV with `b_zero`=0 → C_ISSUE.
  - OP_DIV with `b_zero`=1 → C_ERR.
  - Illegal op → C_ERR.
- **C_ISSUE** (exactly 1 cycle)
  - `unit_start`=1, `unit_sel` from the latched op, `cyc_cnt`←0.
  - `calc_en`=1 → C_WAIT.
  - `calc_en`=0 → C_IDLE with `unit_abort` pulse.
- **C_WAIT**
  - `cyc_cnt` increments each cycle, saturating at `TIMEOUT`-1.
  - MUL: at `cyc_cnt`==`MUL_CYCLES`-1 → C_DONE.
  - DIV: `unit_done`=1 → C_DONE.
  - DIV: `cyc_cnt`==`TIMEOUT`-1 with `unit_done`=0 → C_ERR.
- **C_DONE**: `nxt_line`=1 for one cycle.
  - `calc_en`=0 → C_IDLE.
  - `calc_en`=1 → C_DRAIN.
- **C_DRAIN**: no outputs. Wait until `calc_en`=0, then → C_IDLE. This prevents a relaunch on a stale `calc_en`.
- **C_ERR**: `err`=1. Absorbing until `rst`.

Priorities and boundary conditions:
- `calc_en`=0 in C_ISSUE/C_WAIT (abort) beats completion and timeout in the same cycle: → C_IDLE, `unit_abort`=1, no `nxt_line`.
- `unit_done` beats timeout when both occur on the `TIMEOUT`-1 cycle.
- `unit_done` is ignored in C_IDLE, C_ISSUE, C_DONE and C_DRAIN, and during MUL.
- `op` and `b_zero` changes after launch have no effect.
- `rst` asserted mid-operation clears state immediately. The unit sees no `unit_abort`; its own reset covers it.

## Timing
All outputs are registered or decoded from registered state only, with no input-to-output combinational paths. Take launch to be the edge where C_IDLE samples `calc_en`=1.
- ALU: `nxt_line` high in cycle launch+1. Latency 1.
- MUL: `unit_start` in cycle launch+1, WAIT occupies `MUL_CYCLES` cycles, `nxt_line` in cycle launch+2+`MUL_CYCLES`. Default latency 6.
- DIV: `unit_done` sampled high in WAIT cycle w gives `nxt_line` in cycle w+1. Timeout gives `err` in cycle launch+2+`TIMEOUT`.
- Illegal op / divide by zero: `err` in cycle launch+1.

## Structure
- `params.svh` additions:
  - `CalcState` enum.
  - `CalcOp` enum.
  - OP_* constants.
- One sub-module, `cycle_counter`:
  - Parameterised width.
  - `clr`, `en` and saturating count.
  - Provides `cyc_cnt`.
- The FSM stays in `calc_ctrl`.

## Test plan
- **Reset mid-WAIT.** Stimulus: assert `rst` during MUL WAIT. Required: all outputs 0 asynchronously; a new ALU op completes normally afterwards.
- **ALU and drain.** Stimulus: `op`=0, `calc_en` held high for 5 cycles. Required: single `nxt_line` at launch+1; no second launch (C_DRAIN).
- **MUL latency.** Stimulus: `op`=1, `MUL_CYCLES`=4. Required: `unit_start` at launch+1, `unit_sel`=0, `busy` high for 5 cycles, `nxt_line` at launch+6.
- **DIV completion and abort priority.**
  - Stimulus: `op`=2, `b_zero`=0, `unit_done` at WAIT cycle 3. Required: `nxt_line` the next cycle, `unit_sel`=1.
  - Stimulus: rerun with `calc_en` dropped in the same cycle as `unit_done`. Required: `unit_abort`=1, no `nxt_line`.
- **DIV timeout, done-wins boundary.**
  - Stimulus: no `unit_done`. Required: `err` at launch+18 (`TIMEOUT`=16), sticky.
  - Stimulus: `unit_done` exactly at `cyc_cnt`=15. Required: `nxt_line`, no `err`.
- **Immediate faults.** Stimulus: `op`=2 with `b_zero`=1, and separately `op`=5. Required: `err`=1 at launch+1, `unit_start` never asserted.
